digit_serial_addsub: RTL and testbench
======================================

// Module: digit_serial_addsub
// PURPOSE
//   Parametrised, multi-cycle add/subtract unit for the arithmetic unit.
//   Processes DIGIT bits per clock, least-significant digit first, and
//   carries the carry/borrow between digits in a register.
//   Successor to the 16-bit combinational ripple-borrow subtractor: adds
//   width/digit parametrisation, an add/sub mode, flags and a valid/ready
//   handshake on both sides. Sits between the ALU operand registers and the
//   result mux.
// PARAMETERS
//   WIDTH  16  operand/result width in bits
//   DIGIT  4   bits processed per cycle; WIDTH % DIGIT == 0 (elaboration error otherwise)
//   NDIG   --  localparam = WIDTH/DIGIT, cycles per operation
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      unit can accept; high only in IDLE
//   in0        in   WIDTH  minuend / augend
//   in1        in   WIDTH  subtrahend / addend
//   mode       in   1      0 = add, 1 = subtract
//   cbin       in   1      carry-in (add) / borrow-in (sub)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   res        out  WIDTH  result
//   cbout      out  1      carry-out (add) / borrow-out (sub)
//   ovf        out  1      two's-complement signed overflow
//   zero       out  1      res == 0
// BEHAVIOUR
// - Reset (async): state=IDLE; out_valid=0; res=0; cbout=0; ovf=0; zero=0.
//   in_ready=1 from the first cycle after reset.
// - Reset mid-operation aborts the operation. No out_valid is produced for it.
// - FSM IDLE -> RUN -> DONE -> IDLE.
// - IDLE: on in_valid && in_ready, latch in0, in1, mode and cbin (into the
//   chain register); clear the digit counter; go to RUN.
//   Operand changes after acceptance have no effect.
// - RUN: each cycle process digit k = counter:
//     add: {c, d} = a_k + b_k + c
//     sub: {b, d} = a_k - b_k - b
//   Shift d into res from the MSB side; increment the counter.
//   After digit NDIG-1, register cbout, ovf and zero; go to DONE.
// - Latency: out_valid rises NDIG cycles after the accepting edge.
//   Throughput: one operation per NDIG+2 cycles minimum.
// - DONE: out_valid=1; res and flags held stable while out_ready=0.
//   On out_valid && out_ready, go to IDLE (out_valid=0 on the next cycle).
//   in_ready=0 in RUN and DONE; in_valid is ignored there.
// - Arithmetic is mod 2^WIDTH:
//     add: res = in0+in1+cbin; cbout = carry out of the MSB
//     sub: res = in0-in1-cbin; cbout = 1 iff in0 < in1+cbin (unsigned)
//   ovf (add) = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1])
//   ovf (sub) = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1])
// - DIGIT == WIDTH is legal: one RUN cycle, latency 1.
// STRUCTURE
// - alu_pkg.vh (shared): MODE_ADD=1'b0, MODE_SUB=1'b1,
//   FSM state encodings ST_IDLE/ST_RUN/ST_DONE.
// - Sub-module digit_addsub: combinational DIGIT-bit slice.
//   Ports: a, b, mode, cbin -> d, cbout.
//   sub is implemented as a + ~b + ~bin, with borrow = ~carry.
// - Top level: FSM, counter ($clog2(NDIG+1) bits), operand shift
//   registers, chain register, result shift register, flag registers.
// TESTING (WIDTH=16, DIGIT=4 unless stated)
// 1. rst pulse, then sub 0-0, cbin=0
//    -> res=0, cbout=0, zero=1, ovf=0; out_valid exactly 4 cycles after accept.
// 2. sub 50-100, cbin=1
//    -> res=0xFFCD, cbout=1, ovf=0, zero=0.
// 3. sub 0x8000-0x0001, cbin=0
//    -> res=0x7FFF, cbout=0, ovf=1.
// 4. add 0xFFFF+0x0001, cbin=0
//    -> res=0x0000, cbout=1, zero=1, ovf=0.
//    Also add 0x7FFF+0x0001 -> res=0x8000, ovf=1.
// 5. Hold out_ready=0 for 5 cycles in DONE and pulse in_valid
//    -> res and flags stable, in_ready=0, pulses ignored;
//    the handshake then returns to IDLE.
// 6. Assert rst after 2 RUN cycles
//    -> out_valid never rises for the aborted op, in_ready=1 next cycle.
//    Next op sub 65535-0 -> res=0xFFFF, cbout=0.
//    Repeat tests 1-4 with DIGIT=16 and DIGIT=1 (latency 1 / 16).

Source files
------------

// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
package digit_serial_addsub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/digit_serial_addsub_digit.sv
// Combinational DIGIT-bit add/subtract slice.
// Subtraction is a + ~b + ~bin; the outgoing borrow is the inverted carry.
module digit_serial_addsub_digit
   import digit_serial_addsub_pkg::*;
#(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             mode,
   input  logic             cbin,
   output logic [DIGIT-1:0] d,
   output logic             cbout
);

   logic [DIGIT:0]   sum;
   logic [DIGIT-1:0] b_eff;
   logic             cin;

   // One digit of the ripple chain, carry or borrow depending on mode.
   always_comb begin
      b_eff = (mode == MODE_SUB) ? ~b : b;
      cin   = (mode == MODE_SUB) ? ~cbin : cbin;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
      d     = sum[DIGIT-1:0];
      cbout = (mode == MODE_SUB) ? ~sum[DIGIT] : sum[DIGIT];
   end

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle add/subtract unit: DIGIT bits per clock, LS digit first,
// carry/borrow carried between digits in a chain register.
module digit_serial_addsub
   import digit_serial_addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             mode,
   input  logic             cbin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             cbout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = $clog2(NDIG + 1);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
   logic             mode_q, chain_q, a_msb_q, b_msb_q;
   logic             in_ready_q, out_valid_q, cbout_q, ovf_q, zero_q;
   logic [DIGIT-1:0] dig;
   logic             dig_cb;
   logic             ovf_d, zero_d;

   digit_serial_addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a     (a_q[DIGIT-1:0]),
      .b     (b_q[DIGIT-1:0]),
      .mode  (mode_q),
      .cbin  (chain_q),
      .d     (dig),
      .cbout (dig_cb)
   );

   // Next result word and the flags it would produce if this is the last digit.
   always_comb begin
      res_d = res_q >> DIGIT;
      res_d[WIDTH-1 -: DIGIT] = dig;
      zero_d = (res_d == '0);
      if (mode_q == MODE_SUB)
         ovf_d = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
      else
         ovf_d = (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
   end

   // Control FSM with registered handshake outputs and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         mode_q      <= MODE_ADD;
         chain_q     <= 1'b0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         cbout_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= in0;
                  b_q        <= in1;
                  a_msb_q    <= in0[WIDTH-1];
                  b_msb_q    <= in1[WIDTH-1];
                  mode_q     <= mode;
                  chain_q    <= cbin;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               chain_q <= dig_cb;
               res_q   <= res_d;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cbout_q     <= dig_cb;
                  ovf_q       <= ovf_d;
                  zero_q      <= zero_d;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign res       = res_q;
   assign cbout     = cbout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench: three instances (DIGIT = 4, 16, 1) share the input side.
module tb_digit_serial_addsub;
   import digit_serial_addsub_pkg::*;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, out_ready, mode, cbin;
   logic [W-1:0]  in0, in1;
   logic          in_ready  [3];
   logic          out_valid [3];
   logic          cbout     [3];
   logic          ovf       [3];
   logic          zero      [3];
   logic [W-1:0]  res       [3];
   int            digs      [3] = '{4, 16, 1};
   int            lat       [3];
   int            n_chk  = 0;
   int            n_pass = 0;

   always #5 clk = ~clk;

   digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in0(in0), .in1(in1), .mode(mode), .cbin(cbin),
      .out_valid(out_valid[0]), .out_ready(out_ready), .res(res[0]),
      .cbout(cbout[0]), .ovf(ovf[0]), .zero(zero[0]));

   digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in0(in0), .in1(in1), .mode(mode), .cbin(cbin),
      .out_valid(out_valid[1]), .out_ready(out_ready), .res(res[1]),
      .cbout(cbout[1]), .ovf(ovf[1]), .zero(zero[1]));

   digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
      .in0(in0), .in1(in1), .mode(mode), .cbin(cbin),
      .out_valid(out_valid[2]), .out_ready(out_ready), .res(res[2]),
      .cbout(cbout[2]), .ovf(ovf[2]), .zero(zero[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Issue one operation to all three instances, check latency and results,
   // optionally hold DONE with in_valid pulses, then release.
   task automatic run_op(input string tag, input logic m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c, input logic [W-1:0] er,
                         input logic ec, input logic eo, input logic ez, input bit hold);
      string t;
      @(negedge clk);
      in0 = a; in1 = b; mode = m; cbin = c; in_valid = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) chk($sformatf("%s_d%0d_in_ready", tag, digs[i]), in_ready[i], 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in0 = ~a; in1 = ~b; mode = ~m; cbin = ~c;
      for (int i = 0; i < 3; i++) begin
         lat[i] = 0;
         chk($sformatf("%s_d%0d_busy", tag, digs[i]), {in_ready[i], out_valid[i]}, 0);
      end
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < 3; i++) if (out_valid[i] && lat[i] == 0) lat[i] = k;
      end
      for (int i = 0; i < 3; i++) begin
         t = $sformatf("%s_d%0d", tag, digs[i]);
         chk({t, "_latency"}, lat[i], 16 / digs[i]);
         chk({t, "_out_valid"}, out_valid[i], 1);
         chk({t, "_in_ready"}, in_ready[i], 0);
         chk({t, "_res"}, res[i], er);
         chk({t, "_flags"}, {cbout[i], ovf[i], zero[i]}, {ec, eo, ez});
      end
      if (hold) begin
         for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0); in0 = 16'h5555; in1 = 16'h1111;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
               t = $sformatf("%s_hold%0d_d%0d", tag, k, digs[i]);
               chk({t, "_res"}, res[i], er);
               chk({t, "_state"}, {out_valid[i], in_ready[i], cbout[i], ovf[i], zero[i]},
                   {1'b1, 1'b0, ec, eo, ez});
            end
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         chk($sformatf("%s_d%0d_release", tag, digs[i]), {out_valid[i], in_ready[i]}, 2'b01);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = MODE_ADD; cbin = 1'b0;
      in0 = '0; in1 = '0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset_d%0d", digs[i]),
             {out_valid[i], res[i], cbout[i], ovf[i], zero[i]}, 0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("post_reset_ready_d%0d", digs[i]), in_ready[i], 1);

      run_op("t1_sub_0_0",      MODE_SUB, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      run_op("t2_sub_50_100",   MODE_SUB, 16'd50,   16'd100,  1'b1, 16'hFFCD, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("t3_sub_8000_1",   MODE_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("t4_add_ffff_1",   MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("t4b_add_7fff_1",  MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("t5_add_hold",     MODE_ADD, 16'h1234, 16'h0FCD, 1'b1, 16'h2202, 1'b0, 1'b0, 1'b0, 1'b1);

      // Abort an operation with reset after two RUN cycles.
      @(negedge clk);
      in0 = 16'h1111; in1 = 16'h2222; mode = MODE_ADD; cbin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("t6_pre_abort_d4", out_valid[0], 0);
      chk("t6_pre_abort_d1", out_valid[2], 0);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("t6_async_ready_d%0d", digs[i]), in_ready[i], 1);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 0 || k == 19)
            for (int i = 0; i < 3; i++)
               chk($sformatf("t6_idle%0d_d%0d", k, digs[i]), {out_valid[i], in_ready[i]}, 2'b01);
      end
      run_op("t6_sub_ffff_0",   MODE_SUB, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
